// File: rtl/data_break_arbiter_if.sv
// Data-break bus between the two requesters, the arbiter and the CPU.
// The requester and CPU side drives the master modport; the arbiter uses slave.
interface data_break_arbiter_if;
   // Requester 0 (RK8E disk) and requester 1 (auxiliary device)
   logic        req0;
   logic        req1;
   logic        to_disk0;
   logic        to_disk1;
   logic [0:14] addr0;
   logic [0:14] addr1;
   logic [0:11] wdata0;
   logic [0:11] wdata1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [0:11] rdata;

   // CPU break port
   logic        data_break;
   logic        to_disk;
   logic [0:14] dmaAddr;
   logic [0:11] dmaDOUT;
   logic [0:11] dmaDIN;
   logic        break_in_prog;

   logic        busy;

   modport master (
      output req0, req1, to_disk0, to_disk1, addr0, addr1, wdata0, wdata1,
      output dmaDIN, break_in_prog,
      input  ack0, ack1, err0, err1, rdata,
      input  data_break, to_disk, dmaAddr, dmaDOUT, busy
   );

   modport slave (
      input  req0, req1, to_disk0, to_disk1, addr0, addr1, wdata0, wdata1,
      input  dmaDIN, break_in_prog,
      output ack0, ack1, err0, err1, rdata,
      output data_break, to_disk, dmaAddr, dmaDOUT, busy
   );
endinterface

// File: rtl/data_break_arbiter.sv
// Two-requester round-robin data-break arbiter. Grants one requester, raises
// data_break to the CPU, waits for the break cycle (or a timeout), then
// reports completion with a one-cycle ack or err pulse to the winner.
module data_break_arbiter #(
   parameter logic [9:0] TIMEOUT = 10'd1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   data_break_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BREAK = 2'd2
   } state_t;

   state_t     state;
   logic [9:0] wait_cnt;
   logic       last_grant;   // requester granted by the last completed break
   logic       winner;       // requester owning the current break
   logic       next_winner;

   // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
      if (r0 && r1) begin
         return ~last;
      end
      return r1;
   endfunction

   assign next_winner = pick_winner(bus.req0, bus.req1, last_grant);

   // Arbitration FSM with all outputs registered; clear aborts to IDLE but keeps data outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         wait_cnt       <= 10'd0;
         last_grant     <= 1'b1;
         winner         <= 1'b0;
         bus.data_break <= 1'b0;
         bus.to_disk    <= 1'b0;
         bus.dmaAddr    <= 15'd0;
         bus.dmaDOUT    <= 12'd0;
         bus.rdata      <= 12'd0;
         bus.ack0       <= 1'b0;
         bus.ack1       <= 1'b0;
         bus.err0       <= 1'b0;
         bus.err1       <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         // Completion pulses last exactly one cycle.
         bus.ack0 <= 1'b0;
         bus.ack1 <= 1'b0;
         bus.err0 <= 1'b0;
         bus.err1 <= 1'b0;

         if (clear) begin
            state          <= IDLE;
            wait_cnt       <= 10'd0;
            last_grant     <= 1'b1;
            bus.data_break <= 1'b0;
            bus.busy       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // break_in_prog is deliberately not looked at here.
                  if (bus.req0 || bus.req1) begin
                     winner         <= next_winner;
                     bus.dmaAddr    <= next_winner ? bus.addr1    : bus.addr0;
                     bus.dmaDOUT    <= next_winner ? bus.wdata1   : bus.wdata0;
                     bus.to_disk    <= next_winner ? bus.to_disk1 : bus.to_disk0;
                     bus.data_break <= 1'b1;
                     bus.busy       <= 1'b1;
                     wait_cnt       <= 10'd0;
                     state          <= REQ;
                  end
               end

               REQ: begin
                  if (bus.break_in_prog) begin
                     bus.data_break <= 1'b0;
                     state          <= BREAK;
                  end else if (wait_cnt == TIMEOUT) begin
                     // Abandon the break; the pointer is left alone so the
                     // same arbitration outcome can recur.
                     bus.err0       <= ~winner;
                     bus.err1       <= winner;
                     bus.data_break <= 1'b0;
                     bus.busy       <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     // Stops at TIMEOUT, so the counter can never wrap.
                     wait_cnt <= wait_cnt + 10'd1;
                  end
               end

               BREAK: begin
                  // Entered with break_in_prog high, so a low sample is its falling edge.
                  if (!bus.break_in_prog) begin
                     bus.ack0   <= ~winner;
                     bus.ack1   <= winner;
                     if (bus.to_disk) begin
                        bus.rdata <= bus.dmaDIN;
                     end
                     last_grant <= winner;
                     bus.busy   <= 1'b0;
                     state      <= IDLE;
                  end
               end

               default: begin
                  bus.data_break <= 1'b0;
                  bus.busy       <= 1'b0;
                  state          <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
